// File: rtl/gate_tt_sequencer.sv
// Stimulus driver and truth-table checker for a two-input gate under test.
// Optional GATE_TT_CAPTURE_EN adds o_tt, the i_Y values captured in the last pass.
module gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1,
  localparam int unsigned ERR_W        = $clog2(4 * PASSES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic             i_Y,
  output logic             o_A,
  output logic             o_B,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt
`ifdef GATE_TT_CAPTURE_EN
  ,
  output logic [3:0]       o_tt
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              a_d, b_d, busy_d, done_d, pass_ok_d;
  logic [ERR_W-1:0]  err_d;
  logic              exp_y;
`ifdef GATE_TT_CAPTURE_EN
  logic [3:0]        tt_d;
`endif

  // Reference truth table; unknown op codes fall back to OR
  function automatic logic expected(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd1:    expected = ~(a | b);
      3'd2:    expected = a & b;
      3'd3:    expected = ~(a & b);
      3'd4:    expected = a ^ b;
      default: expected = a | b;
    endcase
  endfunction

  assign exp_y = expected(op_q, idx_q[1], idx_q[0]);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = o_A;
    b_d       = o_B;
    busy_d    = o_busy;
    done_d    = 1'b0;
    pass_ok_d = o_pass;
    err_d     = o_err_cnt;
`ifdef GATE_TT_CAPTURE_EN
    tt_d      = o_tt;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          op_d      = i_op;
          err_d     = '0;
          pass_ok_d = 1'b0;
          idx_d     = 2'd0;
          pass_d    = '0;
          cnt_d     = '0;
          a_d       = 1'b0;
          b_d       = 1'b0;
          busy_d    = 1'b1;
`ifdef GATE_TT_CAPTURE_EN
          tt_d      = 4'd0;
`endif
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (i_Y != exp_y) err_d = o_err_cnt + ERR_W'(1);
`ifdef GATE_TT_CAPTURE_EN
        tt_d[idx_q] = i_Y;
`endif
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          a_d     = idx_d[1];
          b_d     = idx_d[0];
          state_d = HOLD;
        end else if (pass_q != PASS_W'(PASSES - 1)) begin
          idx_d   = 2'd0;
          pass_d  = pass_q + PASS_W'(1);
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = HOLD;
        end else begin
          a_d       = 1'b0;
          b_d       = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          pass_ok_d = (err_d == '0);
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      pass_q    <= '0;
      cnt_q     <= '0;
      op_q      <= 3'd0;
      o_A       <= 1'b0;
      o_B       <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_pass    <= 1'b0;
      o_err_cnt <= '0;
`ifdef GATE_TT_CAPTURE_EN
      o_tt      <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      o_A       <= a_d;
      o_B       <= b_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_pass    <= pass_ok_d;
      o_err_cnt <= err_d;
`ifdef GATE_TT_CAPTURE_EN
      o_tt      <= tt_d;
`endif
    end
  end

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
- Upstream driver and downstream checker for the two-input logic gate under test.
- Drives i_A/i_B of the gate through all four input vectors and samples its o_Y after a programmable settle time.
- Compares each sample against the expected truth table for the selected gate type, then reports a pass/fail verdict and an error count.
- Sits in the lab top level, wrapped around the gate instance. Replaces manual stimulus in the bench.

Parameters:
- SETTLE_CYCLES, 1, extra cycles each vector is held before i_Y is sampled (range 0..15).
- PASSES, 1, number of full 4-vector sweeps per start (range 1..8).

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle start request; honoured only in IDLE.
- i_op  in  3  gate type: 0 OR, 1 NOR, 2 AND, 3 NAND, 4 XOR, 5..7 treated as OR. Latched at start.
- i_Y  in  1  gate output under test.
- o_A  out  1  driven gate input A.
- o_B  out  1  driven gate input B.
- o_busy  out  1  high while a sweep is in progress.
- o_done  out  1  one-cycle pulse when all passes are complete.
- o_pass  out  1  1 if o_err_cnt==0 at completion; held until next start.
- o_err_cnt  out  ERR_W  mismatch count, where ERR_W=$clog2(4*PASSES+1). Held until next start.

Behaviour:
- Reset: FSM goes to IDLE. o_A, o_B, o_busy, o_done, o_pass all 0. o_err_cnt 0. Internal vector index, pass counter and settle counter all 0.
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE:
  - Stays in IDLE unless i_start=1.
  - On i_start=1: latch i_op, clear o_err_cnt and o_pass, set index=0 and pass=0, go to HOLD.
  - In the next cycle: o_busy=1, o_A=index[1], o_B=index[0].
- HOLD:
  - Outputs are held.
  - The settle counter counts SETTLE_CYCLES cycles, then goes to SAMPLE.
  - With SETTLE_CYCLES=0, HOLD lasts 1 cycle.
- SAMPLE:
  - Compare i_Y with expected(op, A, B); on mismatch, o_err_cnt += 1.
  - If index<3: index++, drive the new vector, go to HOLD.
  - If index==3 and pass<PASSES-1: index=0, pass++, go to HOLD.
  - Otherwise go to DONE.
- DONE (1 cycle): o_done=1, o_busy=0, o_pass=(o_err_cnt==0), o_A=o_B=0, then go to IDLE.
- Each vector occupies SETTLE_CYCLES+1 HOLD cycles plus 1 SAMPLE cycle.
- Latency: start accepted in cycle 0 → o_done high in cycle 4*PASSES*(SETTLE_CYCLES+2)+1. With defaults, cycle 13.
- i_start while not in IDLE is ignored; no restart and no queueing.
- i_start in the same cycle as o_done is ignored; the next start is accepted in IDLE.
- i_op changes mid-sweep have no effect.
- i_Y is sampled only in SAMPLE; glitches in HOLD are ignored.
- o_err_cnt cannot overflow (max 4*PASSES fits in ERR_W).
- i_rst mid-sweep: all outputs return to reset values on the next edge and the sweep is abandoned, with no o_done.
- i_rst takes priority over i_start in the same cycle.

Optional Feature:
- Macro: GATE_TT_CAPTURE_EN.
- Defined:
  - Adds output port o_tt (4 bits). Bit n holds the i_Y sampled for vector index n in the last pass.
  - o_tt resets to 0, is cleared on start, and is held after DONE.
- Undefined: the o_tt port and its register are absent. All other behaviour is identical.

Test Plan:
- AND gate, op=2, defaults, start at cycle 0 → vectors 00,01,10,11 in order; o_done at cycle 13; o_pass=1; o_err_cnt=0; o_tt=4'b1000 with capture enabled.
- XOR gate, op=4, i_Y forced to 0 → o_pass=0, o_err_cnt=2, o_tt=4'b0000.
- op=6 against an OR gate, PASSES=2, SETTLE_CYCLES=0 → treated as OR; o_done at cycle 17; o_pass=1.
- i_start pulsed again at cycle 5 of a sweep → ignored; o_done still at cycle 13; o_err_cnt unchanged.
- i_rst asserted at cycle 6 of a NAND sweep → next cycle o_busy=0, o_A=o_B=0, o_err_cnt=0, no o_done; a new start completes normally.
- SETTLE_CYCLES=3, NOR gate with a 2-cycle propagation delay → no errors; each vector held 4 cycles before sampling.
